// File: rtl/ifu_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit: state
// encodings, fault codes, the NOP instruction and the reset-assert level.
package ifu_fetch_pkg;

  localparam int          IFU_ADDR_W     = 32;
  localparam int          IFU_INST_W     = 32;
  localparam logic [31:0] IFU_NOP_INST   = 32'h0000_0013;  // addi x0,x0,0
  localparam logic        IFU_RST_ASSERT = 1'b0;           // rst is active-low

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  typedef enum logic [1:0] {
    IFU_FAULT_NONE     = 2'b00,
    IFU_FAULT_MISALIGN = 2'b01,
    IFU_FAULT_BUS      = 2'b10
  } ifu_fault_e;

  // Instructions are word aligned; the two LSBs of a valid PC are zero.
  function automatic logic ifu_pc_aligned(input logic [1:0] pc_lsb);
    return (pc_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_fetch_outbuf.sv
// Output register slice toward decode. Holds the instruction, its PC, the
// fault code and the valid flag. Load has priority over clear; with neither
// asserted every field holds, which keeps the outputs stable under
// backpressure.
module ifu_fetch_outbuf
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                INST_W   = IFU_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = IFU_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [INST_W-1:0] i_inst,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [1:0]        i_fault,
  output logic              o_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic [1:0]        o_fault
);

  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_fault;

  // Load a new entry, retire the current one, or hold.
  always_ff @(posedge clk) begin
    if (rst == IFU_RST_ASSERT) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_pc    <= '0;
      r_fault <= IFU_FAULT_NONE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
      r_fault <= i_fault;
    end else if (i_clear) begin
      // PC is left as-is; it is meaningless while valid is low.
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_fault <= IFU_FAULT_NONE;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_fault = r_fault;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit. Takes one PC from the PC stage, issues a single
// instruction-memory read over req/gnt/rvalid and presents the result to
// decode through valid/ready. One transaction in flight at most, no prefetch.
//
// state | meaning
// IDLE  | ready for a PC; only state in which stall is low
// REQ   | request on the bus, waiting for gnt
// WAIT  | request granted, waiting for rvalid (discard set after a flush)
// HOLD  | instruction (or misalignment fault) presented to decode
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                INST_W   = IFU_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = IFU_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i_ifu,
  input  logic [ADDR_W-1:0] pc_i_ifu,
  input  logic              flush_i_ifu,
  output logic              pc_stall_o_ifu,
  output logic              imem_req_o_ifu,
  output logic [ADDR_W-1:0] imem_addr_o_ifu,
  input  logic              imem_gnt_i_ifu,
  input  logic              imem_rvalid_i_ifu,
  input  logic [INST_W-1:0] imem_rdata_i_ifu,
  input  logic              imem_err_i_ifu,
  output logic              inst_valid_o_ifu,
  output logic [INST_W-1:0] inst_o_ifu,
  output logic [ADDR_W-1:0] inst_pc_o_ifu,
  output logic [1:0]        fault_o_ifu,
  input  logic              id_ready_i_ifu
);

  ifu_state_e        r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_discard;

  logic              w_aligned;
  logic              w_load_misalign;
  logic              w_load_fetch;
  logic              w_load;
  logic              w_clear;
  logic              w_valid;
  logic [INST_W-1:0] w_ld_inst;
  logic [ADDR_W-1:0] w_ld_pc;
  logic [1:0]        w_ld_fault;

  assign w_aligned = ifu_pc_aligned(pc_i_ifu[1:0]);

  // A misaligned PC never reaches the bus; it goes straight to decode as a
  // faulting NOP.
  assign w_load_misalign = (r_state == IFU_IDLE) && ce_i_ifu && !w_aligned;

  // Response is only kept if nothing has flushed it, now or earlier.
  assign w_load_fetch = (r_state == IFU_WAIT) && imem_rvalid_i_ifu &&
                        !r_discard && !flush_i_ifu;

  assign w_load  = w_load_misalign || w_load_fetch;

  // Handshake and flush both retire the held entry; together they act the same.
  assign w_clear = (r_state == IFU_HOLD) && w_valid &&
                   (id_ready_i_ifu || flush_i_ifu);

  // Select what gets loaded into the output slice.
  always_comb begin
    w_ld_inst  = NOP_INST;
    w_ld_pc    = pc_i_ifu;
    w_ld_fault = IFU_FAULT_MISALIGN;
    if (w_load_fetch) begin
      w_ld_inst  = imem_rdata_i_ifu;
      w_ld_pc    = r_addr;
      w_ld_fault = imem_err_i_ifu ? IFU_FAULT_BUS : IFU_FAULT_NONE;
    end
  end

  // Fetch sequencer: state, bus request, address and discard flag.
  always_ff @(posedge clk) begin
    if (rst == IFU_RST_ASSERT) begin
      r_state   <= IFU_IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        IFU_IDLE: begin
          if (ce_i_ifu && !w_aligned) begin
            r_state <= IFU_HOLD;
          end else if (ce_i_ifu && !flush_i_ifu) begin
            r_addr  <= pc_i_ifu;
            r_req   <= 1'b1;
            r_state <= IFU_REQ;
          end
        end
        IFU_REQ: begin
          // Flush wins over a same-cycle gnt: the request is simply withdrawn.
          if (flush_i_ifu) begin
            r_req   <= 1'b0;
            r_state <= IFU_IDLE;
          end else if (imem_gnt_i_ifu) begin
            r_req   <= 1'b0;
            r_state <= IFU_WAIT;
          end
        end
        IFU_WAIT: begin
          // A granted read is owned and must be drained even when flushed.
          if (imem_rvalid_i_ifu) begin
            r_discard <= 1'b0;
            r_state   <= (r_discard || flush_i_ifu) ? IFU_IDLE : IFU_HOLD;
          end else if (flush_i_ifu) begin
            r_discard <= 1'b1;
          end
        end
        IFU_HOLD: begin
          if (w_clear || !w_valid) begin
            r_state <= IFU_IDLE;
          end
        end
        default: begin
          r_state <= IFU_IDLE;
        end
      endcase
    end
  end

  ifu_fetch_outbuf #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .NOP_INST (NOP_INST)
  ) u_outbuf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_inst  (w_ld_inst),
    .i_pc    (w_ld_pc),
    .i_fault (w_ld_fault),
    .o_valid (w_valid),
    .o_inst  (inst_o_ifu),
    .o_pc    (inst_pc_o_ifu),
    .o_fault (fault_o_ifu)
  );

  assign inst_valid_o_ifu = w_valid;
  assign imem_req_o_ifu   = r_req;
  assign imem_addr_o_ifu  = r_addr;
  assign pc_stall_o_ifu   = (r_state != IFU_IDLE);

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit sitting directly downstream of the PC register. It takes the PC value and chip-enable from the PC stage and issues one instruction-memory read per PC over a req/gnt/rvalid bus. It delivers the fetched instruction plus its PC to decode through a valid/ready handshake. It also drives a stall back toward the PC stage and honours branch flushes.

Parameters:
ADDR_W, 32, instruction address width
INST_W, 32, instruction width
NOP_INST, 32'h00000013, value driven on inst_o_ifu when no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-low reset
ce_i_ifu  in  1  PC-stage chip enable; PC valid when high
pc_i_ifu  in  ADDR_W  PC to fetch
flush_i_ifu  in  1  branch taken / redirect; kills the fetch in progress
pc_stall_o_ifu  out  1  high when the unit cannot accept a new PC this cycle
imem_req_o_ifu  out  1  memory read request
imem_addr_o_ifu  out  ADDR_W  request address; stable while req high and not granted
imem_gnt_i_ifu  in  1  memory accepts the request this cycle
imem_rvalid_i_ifu  in  1  read data valid
imem_rdata_i_ifu  in  INST_W  read data
imem_err_i_ifu  in  1  bus error, qualified by rvalid
inst_valid_o_ifu  out  1  instruction available to decode
inst_o_ifu  out  INST_W  instruction (NOP_INST when not valid)
inst_pc_o_ifu  out  ADDR_W  PC of inst_o_ifu
fault_o_ifu  out  2  00 none, 01 misaligned PC, 10 bus error; qualified by inst_valid_o_ifu
id_ready_i_ifu  in  1  decode accepts the instruction

Behaviour:
- Reset: posedge clk with rst==0. State goes to IDLE. req=0, addr=0, inst_valid=0, inst=NOP_INST, inst_pc=0, fault=00, discard flag=0. Reset wins over every other input, mid-transaction included. A memory response left outstanding at reset is the memory's responsibility.
- FSM states: IDLE, REQ, WAIT, HOLD. All outputs are registered except pc_stall_o_ifu.
- IDLE:
  - ce=1, pc[1:0]==00, no flush: latch pc into addr, go to REQ.
  - ce=1, pc[1:0]!=00: no bus access. Load inst_valid=1, fault=01, inst=NOP_INST, inst_pc=pc. Go to HOLD.
  - ce=0: stay in IDLE.
- REQ:
  - req=1, addr held stable.
  - gnt=1: go to WAIT (req drops next cycle).
  - flush=1: drop the request, go to IDLE. Flush beats gnt in the same cycle. If gnt was already sampled, the transaction is owned, so go to WAIT with discard=1.
- WAIT:
  - rvalid=1 with discard=0 and no flush: load inst=rdata, inst_pc=addr, fault=(err?10:00), valid=1. Go to HOLD.
  - rvalid=1 with discard=1 or flush=1: drop the data, clear discard, go to IDLE.
  - flush without rvalid: set discard, stay in WAIT.
- HOLD:
  - Outputs stay stable while valid && !id_ready.
  - Handshake (valid && id_ready): clear valid, inst=NOP_INST, go to IDLE.
  - flush: same as handshake (clear valid, go to IDLE). Flush together with id_ready behaves identically.
- pc_stall_o_ifu = (state!=IDLE). The PC stage must hold its PC while stall is high. The current PC stage ignores this signal; that wiring is a planned follow-on.
- Minimum latency with gnt and rvalid each in the earliest cycle:
  - PC sampled in IDLE at cycle N.
  - req high at N+1, gnt at N+1.
  - rvalid at N+2.
  - inst_valid high at N+3.
  - Back-to-back throughput is one instruction per 4 cycles. No prefetch.
- Only one transaction is outstanding at a time. An rvalid seen in IDLE/REQ/HOLD is a protocol violation and is ignored.

Decomposition:
- Shared constants in define.v:
  - IFU state encodings: 2-bit IDLE=0, REQ=1, WAIT=2, HOLD=3
  - fault codes
  - NOP_INST
  - active-low reset-assert level for this block
  - existing InstBus/InstAddrBus widths reused
- One natural sub-module: ifu_outbuf, the output register slice holding inst/inst_pc/fault/valid with load, clear and hold controls, driven by the FSM in ifu_fetch.

Test Plan:
- Reset: rst=0 for 2 cycles with ce=1 and random bus inputs -> req=0, inst_valid=0, inst=0x00000013, stall=0. Release: pc=0x80000000 -> req at next cycle with addr=0x80000000.
- Zero-wait fetch: gnt immediate, rvalid+rdata=0x00100093 one cycle later, id_ready=1 -> inst_valid high exactly 3 cycles after PC sampled, inst=0x00100093, inst_pc=0x80000000, fault=00, valid for 1 cycle.
- Backpressure: id_ready=0 for 5 cycles after valid -> inst/inst_pc stable all 5 cycles, stall=1, no new req; id_ready=1 -> valid drops next cycle.
- Flush in WAIT: gnt taken, flush pulsed, rvalid arrives 3 cycles later with 0xDEADBEEF -> never presented (inst_valid stays 0), return to IDLE; next pc=0x80000010 fetched normally.
- Misaligned and error: pc=0x80000002 -> no req, valid with fault=01, inst=NOP. Aligned fetch with err=1 -> valid with fault=10, inst_pc correct.
- Flush in REQ with gnt held low, and flush coincident with id_ready in HOLD -> req drops next cycle / valid clears, no duplicate delivery.
